// File: rtl/flag_unit_pkg.sv
// Shared definitions for the flag register: flag bit positions, the packed
// flag word and the condition codes evaluated by the condition-check logic.
package flag_unit_pkg;

    // Bit positions inside FlagA = {Z, N} and FlagB = {C, V}
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Full flag word, laid out as {Z, N, C, V} so [3:2] is FlagA and [1:0] is FlagB
    typedef logic [3:0] flagWord_t;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Evaluate a condition code against the architectural flag buses
    function automatic logic condPass(input logic [3:0] cond,
                                      input logic [1:0] flagA,
                                      input logic [1:0] flagB);
        logic z;
        logic n;
        logic v;
        z = flagA[FLAG_Z];
        n = flagA[FLAG_N];
        v = flagB[FLAG_V];
        case (cond)
            COND_EQ: condPass = z;
            COND_NE: condPass = !z;
            COND_GE: condPass = (n == v);
            COND_LT: condPass = (n != v);
            COND_GT: condPass = !z && (n == v);
            COND_LE: condPass = z || (n != v);
            COND_AL: condPass = 1'b1;
            default: condPass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/flag_unit_gen.sv
// Combinational derivation of Z/N/C/V from the raw ALU outputs.
module flag_gen
    import flag_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] aluResult,
    input  logic             aluCarry,
    input  logic             aluOverflow,
    output logic [3:0]       flagWord
);

    logic signed [WIDTH-1:0] resultS;

    // Treat the result as two's complement: N is its sign, Z its all-zero test
    always_comb begin
        resultS  = aluResult;
        flagWord = '0;
        flagWord[2 + FLAG_Z] = (resultS == '0);
        flagWord[2 + FLAG_N] = (resultS < 0);
        flagWord[FLAG_C]     = aluCarry;
        flagWord[FLAG_V]     = aluOverflow;
    end

endmodule

// File: rtl/flag_unit.sv
// Architectural flag register with a two-stage update pipeline (capture in
// E, commit in W) and a one-entry shadow for interrupt save/restore.
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             set_flags,
    input  logic             cond_ex,
    input  logic             flush,
    input  logic             save_req,
    input  logic             restore_req,
    output logic [1:0]       FlagA,
    output logic [1:0]       FlagB,
    output logic             flags_pending
);

    logic [3:0] genFlags;
    flagWord_t  flags_p1;
    logic       vld_p1;
    flagWord_t  archFlags_p2;
    flagWord_t  shadowFlags;
    logic       captureReq;
    logic       commit;

    flag_gen #(
        .WIDTH(WIDTH)
    ) uFlagGen (
        .aluResult  (alu_result),
        .aluCarry   (alu_carry),
        .aluOverflow(alu_overflow),
        .flagWord   (genFlags)
    );

    // Restore beats flush beats capture/commit; either one kills both stages
    always_comb begin
        captureReq = alu_valid && set_flags && cond_ex && !flush && !restore_req;
        commit     = vld_p1 && !flush && !restore_req;
    end

    // ---- Stage E: capture derived flags (data needs no reset, vld_p1 guards it)
    always_ff @(posedge clk) begin
        flags_p1 <= genFlags;
    end

    // Stage E valid bit, which is also the exported pending indication
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= captureReq;
        end
    end

    // ---- Stage W: architectural flags and shadow; save reads the pre-commit value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            archFlags_p2 <= '0;
            shadowFlags  <= '0;
        end else begin
            if (restore_req) begin
                archFlags_p2 <= shadowFlags;
            end else if (commit) begin
                archFlags_p2 <= flags_p1;
            end
            if (save_req) begin
                shadowFlags <= archFlags_p2;
            end
        end
    end

    assign FlagA         = archFlags_p2[3:2];
    assign FlagB         = archFlags_p2[1:0];
    assign flags_pending = vld_p1;

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit with hand-computed expected values.
module tb_flag_unit;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             alu_valid;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_overflow;
    logic             set_flags;
    logic             cond_ex;
    logic             flush;
    logic             save_req;
    logic             restore_req;
    logic [1:0]       FlagA;
    logic [1:0]       FlagB;
    logic             flags_pending;

    int checkCount = 0;
    int passCount  = 0;

    flag_unit #(
        .WIDTH(WIDTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .set_flags    (set_flags),
        .cond_ex      (cond_ex),
        .flush        (flush),
        .save_req     (save_req),
        .restore_req  (restore_req),
        .FlagA        (FlagA),
        .FlagB        (FlagB),
        .flags_pending(flags_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; outputs are sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // Check FlagA, FlagB and pending together
    task automatic checkAll(input string tag, input logic [1:0] expA,
                            input logic [1:0] expB, input logic expP);
        check({tag, ".FlagA"}, {2'b00, FlagA}, {2'b00, expA});
        check({tag, ".FlagB"}, {2'b00, FlagB}, {2'b00, expB});
        check({tag, ".pend"},  {3'b000, flags_pending}, {3'b000, expP});
    endtask

    task automatic idle();
        alu_valid    = 1'b0;
        alu_result   = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        set_flags    = 1'b0;
        cond_ex      = 1'b0;
        flush        = 1'b0;
        save_req     = 1'b0;
        restore_req  = 1'b0;
    endtask

    task automatic capture(input logic [WIDTH-1:0] res, input logic c, input logic v);
        alu_valid    = 1'b1;
        alu_result   = res;
        alu_carry    = c;
        alu_overflow = v;
        set_flags    = 1'b1;
        cond_ex      = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            alu_valid    = 1'($urandom);
            alu_result   = WIDTH'($urandom);
            alu_carry    = 1'($urandom);
            alu_overflow = 1'($urandom);
            set_flags    = 1'($urandom);
            cond_ex      = 1'($urandom);
            flush        = 1'($urandom);
            save_req     = 1'($urandom);
            restore_req  = 1'($urandom);
            step();
        end
        checkAll("reset", 2'b00, 2'b00, 1'b0);
        idle();
        rst_n = 1'b1;
        restore_req = 1'b1;
        step();
        checkAll("reset_restore", 2'b00, 2'b00, 1'b0);

        // Zero result
        idle();
        capture(16'h0000, 1'b1, 1'b0);
        step();
        checkAll("zero_n1", 2'b00, 2'b00, 1'b1);
        idle();
        step();
        checkAll("zero_n2", 2'b10, 2'b10, 1'b0);

        // Gating: S low, cond_ex low, alu_valid low
        capture(16'h8000, 1'b0, 1'b0);
        set_flags = 1'b0;
        step();
        checkAll("gate_s", 2'b10, 2'b10, 1'b0);
        set_flags = 1'b1;
        cond_ex   = 1'b0;
        step();
        checkAll("gate_cond", 2'b10, 2'b10, 1'b0);
        cond_ex   = 1'b1;
        alu_valid = 1'b0;
        step();
        idle();
        step();
        checkAll("gate_valid", 2'b10, 2'b10, 1'b0);

        // Bring flags to 00/00 as the flush baseline
        capture(16'h0001, 1'b0, 1'b0);
        step();
        idle();
        step();
        checkAll("base", 2'b00, 2'b00, 1'b0);

        // Flush of the in-flight update
        capture(16'h8001, 1'b0, 1'b1);
        step();
        checkAll("flush_n1", 2'b00, 2'b00, 1'b1);
        idle();
        flush = 1'b1;
        step();
        checkAll("flush_n2", 2'b00, 2'b00, 1'b0);
        idle();
        step();
        checkAll("flush_n3", 2'b00, 2'b00, 1'b0);

        // Capture in the same cycle as flush is dropped
        capture(16'h8001, 1'b1, 1'b1);
        flush = 1'b1;
        step();
        checkAll("flush_cap", 2'b00, 2'b00, 1'b0);
        idle();
        step();
        checkAll("flush_cap2", 2'b00, 2'b00, 1'b0);

        // Set 01/01, save it, then restore colliding with a commit
        capture(16'h8000, 1'b0, 1'b1);
        step();
        idle();
        step();
        checkAll("set0101", 2'b01, 2'b01, 1'b0);
        save_req = 1'b1;
        step();
        idle();
        capture(16'h0000, 1'b1, 1'b0);
        step();
        checkAll("mod_n1", 2'b01, 2'b01, 1'b1);
        idle();
        restore_req = 1'b1;
        step();
        checkAll("restore_coll", 2'b01, 2'b01, 1'b0);
        idle();
        step();
        checkAll("restore_hold", 2'b01, 2'b01, 1'b0);

        // Restore drops a same-cycle capture
        capture(16'h0000, 1'b1, 1'b1);
        restore_req = 1'b1;
        step();
        checkAll("restore_cap", 2'b01, 2'b01, 1'b0);
        idle();
        step();
        checkAll("restore_cap2", 2'b01, 2'b01, 1'b0);

        // Back-to-back captures: 0x0001, 0xFFFF, 0x0000
        capture(16'h0001, 1'b0, 1'b0);
        step();
        checkAll("b2b_1", 2'b01, 2'b01, 1'b1);
        capture(16'hFFFF, 1'b1, 1'b0);
        step();
        checkAll("b2b_2", 2'b00, 2'b00, 1'b1);
        capture(16'h0000, 1'b1, 1'b1);
        step();
        checkAll("b2b_3", 2'b01, 2'b10, 1'b1);
        idle();
        step();
        checkAll("b2b_4", 2'b10, 2'b11, 1'b0);

        // Swap: arch 1011 <-> shadow 0101
        save_req    = 1'b1;
        restore_req = 1'b1;
        step();
        checkAll("swap_arch", 2'b01, 2'b01, 1'b0);
        idle();
        restore_req = 1'b1;
        step();
        checkAll("swap_shadow", 2'b10, 2'b11, 1'b0);

        // Reset mid-operation discards the in-flight update
        idle();
        capture(16'h0000, 1'b0, 1'b0);
        step();
        checkAll("midrst_n1", 2'b10, 2'b11, 1'b1);
        idle();
        rst_n = 1'b0;
        step();
        checkAll("midrst_n2", 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        step();
        checkAll("midrst_n3", 2'b00, 2'b00, 1'b0);
        restore_req = 1'b1;
        step();
        checkAll("midrst_rest", 2'b00, 2'b00, 1'b0);
        idle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
